// File: rtl/apb_mux_pkg.sv
// Shared state encodings, slot record and constant helpers for the APB slave mux.
package apb_mux_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_ABORT  = 2'd3;

    // idx is sized for the largest supported slave count (8).
    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } slot_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_wdt_cnt.sv
// PREADY watchdog counter: clear has priority over enable; expired flags the last waited cycle.
module apb_wdt_cnt #(
    parameter int unsigned CNTW    = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNTW-1:0] LIMIT = CNTW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CNTW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/apb_slave_mux_wdt.sv
// APB decoder/mux between the bridge and NSLV slaves, with unmapped-address error,
// PREADY watchdog abort and a software-visible error log.
module apb_slave_mux_wdt
    import apb_mux_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = 16,
    parameter int unsigned NSLV      = 4,
    parameter int unsigned SEL_LSB   = 12,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned CNTW      = 8
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 PCLKEN,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [ADDRWIDTH-1:0] PADDR,
    output logic [31:0]          PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output logic [NSLV-1:0]      PSELX,
    input  logic [32*NSLV-1:0]   PRDATAX,
    input  logic [NSLV-1:0]      PREADYX,
    input  logic [NSLV-1:0]      PSLVERRX,
    output logic [CNTW-1:0]      ERR_CNT,
    output logic [ADDRWIDTH-1:0] ERR_ADDR,
    output logic                 ERR_TO,
    input  logic                 ERR_CLR
);

    localparam int          SEL_RAW = clog2(int'(NSLV));
    localparam int unsigned SELW    = (SEL_RAW < 1) ? 1 : SEL_RAW;

    logic [1:0]           state_q, state_d;
    slot_t                slot_q, slot_d, dec;
    logic [ADDRWIDTH-1:0] upper;
    logic [NSLV-1:0]      live_oh, slot_oh;
    logic                 sel_rdy, sel_err;
    logic [31:0]          sel_rdata;
    logic                 wdt_clr, wdt_en, wdt_expired;
    logic                 log_err, log_to;
    logic [CNTW-1:0]      err_cnt_q, err_cnt_d;
    logic [ADDRWIDTH-1:0] err_addr_q, err_addr_d;
    logic                 err_to_q, err_to_d;
    logic                 unused_pwrite;

    assign unused_pwrite = PWRITE;

    assign upper = PADDR >> (SEL_LSB + SELW);

    always_comb begin
        dec     = '0;
        dec.idx = 3'(PADDR[SEL_LSB +: SELW]);
        dec.hit = (upper == '0) && (32'(dec.idx) < NSLV);
    end

    always_comb begin
        live_oh   = '0;
        slot_oh   = '0;
        sel_rdy   = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < int'(NSLV); i++) begin
            live_oh[i] = dec.hit && (dec.idx == 3'(i));
            slot_oh[i] = slot_q.hit && (slot_q.idx == 3'(i));
            if (slot_oh[i]) begin
                sel_rdy   = PREADYX[i];
                sel_err   = PSLVERRX[i];
                sel_rdata = PRDATAX[32*i +: 32];
            end
        end
    end

    // Upstream response is purely combinational from state, slot and the slave inputs.
    always_comb begin
        PSELX   = '0;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = (state_q == ST_ABORT) ? 32'h0 : sel_rdata;
        case (state_q)
            ST_SETUP: PSELX = live_oh & {NSLV{PSEL}};
            ST_ACCESS: begin
                PSELX = slot_oh & {NSLV{PSEL}};
                if (slot_q.hit) begin
                    PREADY  = sel_rdy;
                    PSLVERR = sel_err & sel_rdy;
                end else begin
                    PREADY  = 1'b1;
                    PSLVERR = 1'b1;
                end
            end
            ST_ABORT: begin
                PREADY  = 1'b1;
                PSLVERR = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        wdt_clr = 1'b0;
        wdt_en  = 1'b0;
        log_err = 1'b0;
        log_to  = 1'b0;
        if (PCLKEN) begin
            case (state_q)
                ST_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        state_d = ST_SETUP;
                        slot_d  = dec;
                    end
                end
                ST_SETUP: begin
                    wdt_clr = 1'b1;
                    state_d = PSEL ? ST_ACCESS : ST_IDLE;
                end
                ST_ACCESS: begin
                    if (!PSEL) begin
                        state_d = ST_IDLE;
                    end else if (!slot_q.hit || sel_rdy) begin
                        log_err = !slot_q.hit || sel_err;
                        if (!PENABLE) begin
                            state_d = ST_SETUP;
                            slot_d  = dec;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (wdt_expired) begin
                        state_d = ST_ABORT;
                    end else begin
                        wdt_en = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    log_err = 1'b1;
                    log_to  = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        err_to_d   = err_to_q;
        if (ERR_CLR) begin
            err_cnt_d  = '0;
            err_addr_d = '0;
            err_to_d   = 1'b0;
        end else if (log_err) begin
            err_addr_d = PADDR;
            err_to_d   = log_to;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            slot_q     <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
            err_to_q   <= err_to_d;
        end
    end

    apb_wdt_cnt #(
        .CNTW    (CNTW),
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk_i     (HCLK),
        .rst_ni    (HRESETn),
        .clr_i     (wdt_clr),
        .en_i      (wdt_en),
        .expired_o (wdt_expired)
    );

    assign ERR_CNT  = err_cnt_q;
    assign ERR_ADDR = err_addr_q;
    assign ERR_TO   = err_to_q;

endmodule

// File: tb/tb_apb_slave_mux_wdt.sv
// Randomised bench for apb_slave_mux_wdt: acts as bridge and slaves, predicts each
// transaction's completion cycle, response and error log from the address map and wait count.
module tb_apb_slave_mux_wdt;

    localparam int unsigned AW = 16;
    localparam int unsigned NS = 4;
    localparam int unsigned TO = 4;
    localparam int unsigned CW = 8;

    logic            HCLK = 1'b0;
    logic            HRESETn, PCLKEN, PSEL, PENABLE, PWRITE, ERR_CLR;
    logic [AW-1:0]   PADDR;
    logic [31:0]     PRDATA;
    logic            PREADY, PSLVERR, ERR_TO;
    logic [NS-1:0]   PSELX, PREADYX, PSLVERRX;
    logic [32*NS-1:0] PRDATAX;
    logic [CW-1:0]   ERR_CNT;
    logic [AW-1:0]   ERR_ADDR;

    apb_slave_mux_wdt #(
        .ADDRWIDTH (AW),
        .NSLV      (NS),
        .SEL_LSB   (12),
        .TIMEOUT   (TO),
        .CNTW      (CW)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .PCLKEN   (PCLKEN),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .PSELX    (PSELX),
        .PRDATAX  (PRDATAX),
        .PREADYX  (PREADYX),
        .PSLVERRX (PSLVERRX),
        .ERR_CNT  (ERR_CNT),
        .ERR_ADDR (ERR_ADDR),
        .ERR_TO   (ERR_TO),
        .ERR_CLR  (ERR_CLR)
    );

    always #5 HCLK = ~HCLK;

    // Slave behaviour: ready once it has seen more than wait_cfg enabled, selected cycles.
    int sel_cnt [NS] = '{default: 0};
    int wait_cfg [NS] = '{default: 1000};

    always @(posedge HCLK) begin
        if (PCLKEN) begin
            for (int i = 0; i < int'(NS); i++) begin
                sel_cnt[i] <= (PSELX[i] && PENABLE) ? sel_cnt[i] + 1 : 0;
            end
        end
    end

    always_comb begin
        PREADYX = '0;
        for (int i = 0; i < int'(NS); i++) PREADYX[i] = (sel_cnt[i] > wait_cfg[i]);
    end

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            en_mode = 0;
    int            m_cnt = 0;
    logic [AW-1:0] m_addr = '0;
    logic          m_to = 1'b0;
    logic [31:0]   rdata [NS];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge HCLK);
        cyc++;
        case (en_mode)
            1:       PCLKEN = ((cyc % 3) == 0);
            2:       PCLKEN = ($urandom_range(1, 0) == 1);
            default: PCLKEN = 1'b1;
        endcase
    endtask

    task automatic check_log(input string tag);
        check_eq({tag, "_cnt"}, ERR_CNT, m_cnt);
        check_eq({tag, "_addr"}, ERR_ADDR, m_addr);
        check_eq({tag, "_to"}, ERR_TO, m_to);
    endtask

    task automatic xfer(input logic [AW-1:0] a, input logic w, input int wt, input logic serr,
                        input logic clr, output int hclk_n);
        logic          hit, abort, err, done;
        int            idx, exp_n, n, steps;
        logic [NS-1:0] oh;
        idx   = int'(a[13:12]);
        hit   = (a[15:14] == 2'b00);
        abort = hit && (wt >= int'(TO));
        err   = !hit || abort || (hit && serr);
        oh    = '0;
        if (hit) oh[idx] = 1'b1;
        exp_n = hit ? (((wt < int'(TO)) ? wt : int'(TO)) + 2) : 2;
        for (int i = 0; i < int'(NS); i++) begin
            wait_cfg[i] = 1000;
            PRDATAX[32*i +: 32] = rdata[i];
        end
        if (hit) wait_cfg[idx] = wt;
        PSLVERRX = serr ? '1 : '0;

        step();
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w;
        #1 check_eq("idle_pselx", PSELX, 0);
        while (!PCLKEN) step();

        n = 0; steps = 0; done = 1'b0;
        while (!done && steps < 400) begin
            step();
            steps++;
            PENABLE = 1'b1;
            #1;
            if (PCLKEN) begin
                n++;
                if (n == 1) check_eq("setup_pselx", PSELX, oh);
                if (PREADY) begin
                    done = 1'b1;
                    check_eq("done_cycle", n, exp_n);
                    check_eq("pslverr", PSLVERR, err);
                    check_eq("prdata", PRDATA, (hit && !abort) ? rdata[idx] : 32'h0);
                    check_eq("done_pselx", PSELX, abort ? '0 : oh);
                    ERR_CLR = clr;
                end
            end
        end
        check_eq("xfer_done", done, 1'b1);
        hclk_n = steps;

        step();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; ERR_CLR = 1'b0;
        if (done) begin
            if (clr) begin
                m_cnt = 0; m_addr = '0; m_to = 1'b0;
            end else if (err) begin
                m_addr = a;
                m_to   = abort;
                if (m_cnt < 255) m_cnt++;
            end
        end
        #1 check_log("log");
    endtask

    function automatic logic [AW-1:0] rand_addr(input logic miss);
        logic [AW-1:0] a;
        a = AW'($urandom);
        if (miss) begin
            if (a[15:14] == 2'b00) a[15] = 1'b1;
        end else begin
            a[15:14] = 2'b00;
        end
        return a;
    endfunction

    initial begin
        int            hn;
        logic [AW-1:0] a;
        HRESETn = 1'b0; PCLKEN = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; ERR_CLR = 1'b0; PSLVERRX = '0;
        for (int i = 0; i < int'(NS); i++) begin
            rdata[i] = $urandom;
            PRDATAX[32*i +: 32] = rdata[i];
        end
        #12;
        check_eq("rst_pselx", PSELX, 0);
        check_eq("rst_pready", PREADY, 0);
        check_eq("rst_pslverr", PSLVERR, 0);
        check_eq("rst_prdata", PRDATA, 0);
        check_log("rst");
        step();
        HRESETn = 1'b1;
        step();

        // Slave 2 read with three wait cycles.
        rdata[2] = 32'hA5A5_0002;
        xfer(16'h2004, 1'b0, 3, 1'b0, 1'b0, hn);
        // Unmapped write.
        xfer(16'h8000, 1'b1, 0, 1'b0, 1'b0, hn);
        // Hung slave 1 aborted by the watchdog.
        xfer(16'h1000, 1'b0, 100, 1'b0, 1'b0, hn);
        // Ready arrives on the last cycle before the watchdog would fire.
        xfer(16'h0000, 1'b0, int'(TO) - 1, 1'b0, 1'b0, hn);
        // Slave error response.
        xfer(16'h3ffc, 1'b1, 1, 1'b1, 1'b0, hn);
        // Clear coinciding with an error completion wins.
        xfer(16'hc000, 1'b0, 0, 1'b0, 1'b1, hn);

        // PCLKEN one-in-three stretches the access to 3x HCLK cycles.
        en_mode = 1;
        xfer(16'h0040, 1'b0, 2, 1'b0, 1'b0, hn);
        check_eq("div3_hclk", hn, 3 * 4);
        en_mode = 0;

        for (int t = 0; t < 150; t++) begin
            en_mode = ($urandom_range(2, 0) == 0) ? 2 : 0;
            for (int i = 0; i < int'(NS); i++) rdata[i] = $urandom;
            a = rand_addr($urandom_range(3, 0) == 0);
            xfer(a, 1'($urandom_range(1, 0)), int'($urandom_range(6, 0)),
                 ($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0), hn);
        end
        en_mode = 0;

        // PSEL dropped mid-access: back to idle, nothing logged.
        wait_cfg[3] = 1000;
        step();
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 16'h3010;
        step();
        PENABLE = 1'b1;
        step();
        #1 check_eq("drop_pselx_busy", PSELX, 4'b1000);
        PSEL = 1'b0;
        step();
        PENABLE = 1'b0;
        #1 check_eq("drop_pselx_idle", PSELX, 0);
        check_eq("drop_pready", PREADY, 0);
        check_log("drop");

        for (int t = 0; t < 300; t++) xfer(16'h4000 | AW'(t), 1'b0, 0, 1'b0, 1'b0, hn);
        check_eq("sat_cnt", ERR_CNT, 8'hff);
        xfer(16'h2000, 1'b0, 100, 1'b0, 1'b0, hn);
        check_eq("sat_abort_to", ERR_TO, 1'b1);
        step();
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        m_cnt = 0; m_addr = '0; m_to = 1'b0;
        #1 check_log("clr");

        // Reset asserted in the middle of a hung access.
        xfer(16'hf000, 1'b0, 0, 1'b0, 1'b0, hn);
        wait_cfg[1] = 1000;
        step();
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 16'h1000;
        step();
        PENABLE = 1'b1;
        step();
        #1 check_eq("mid_pselx_busy", PSELX, 4'b0010);
        #1 HRESETn = 1'b0;
        m_cnt = 0; m_addr = '0; m_to = 1'b0;
        #1 check_eq("mid_rst_pselx", PSELX, 0);
        check_eq("mid_rst_pready", PREADY, 0);
        check_log("mid_rst");
        step();
        HRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
        rdata[1] = 32'h1234_5678;
        xfer(16'h1008, 1'b0, 1, 1'b0, 1'b0, hn);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish before time limit");
        $fatal(1);
    end

endmodule
